// File: rtl/ireg_skew_if.sv
// Handshake and data bundle between the activation feeder and ireg_skew_array.
// The feeder side uses the master modport, the skew register the slave modport.
interface ireg_skew_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                      en;
    logic                      clr;
    logic                      i_valid;
    logic                      i_last;
    logic [CHANNELS*WIDTH-1:0] i_data;
    logic                      i_ready;
    logic [CHANNELS-1:0]       o_valid;
    logic [CHANNELS*WIDTH-1:0] o_data;
    logic                      o_busy;
    logic                      o_done;

    modport master (
        output en, clr, i_valid, i_last, i_data,
        input  i_ready, o_valid, o_data, o_busy, o_done
    );

    modport slave (
        input  en, clr, i_valid, i_last, i_data,
        output i_ready, o_valid, o_data, o_busy, o_done
    );
endinterface

// File: rtl/ireg_skew_array.sv
// West-edge skew register for the systolic array: channel c is delayed BASE_DEPTH+c enabled cycles.
// Optional macro IREG_SKEW_ZERO_FILL_EN: bubbles carry zero data instead of the sampled word.
//
// state | meaning
// IDLE  | no frame open, inputs accepted
// RUN   | frame open, inputs accepted
// DRAIN | last vector accepted, waiting for it to leave the last channel; inputs dropped
module ireg_skew_array #(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 4,
    parameter int BASE_DEPTH = 1
) (
    input logic        clk,
    input logic        rst_n,
    ireg_skew_if.slave bus
);
    localparam int D  = BASE_DEPTH + CHANNELS - 1;
    localparam int CW = $clog2(D) + 1;
    localparam logic [CW-1:0] LOAD = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            ready;
    logic            accept;
    logic            stage0_vld;

    logic [CHANNELS-1:0]       o_valid_w;
    logic [CHANNELS*WIDTH-1:0] o_data_w;

    assign ready      = (state_q != DRAIN);
    assign stage0_vld = bus.i_valid & ready;
    assign accept     = bus.en & stage0_vld & ~bus.clr;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam int DEP = BASE_DEPTH + c;

        logic [DEP-1:0]   vld_q;
        logic [WIDTH-1:0] dat_q [DEP];
        logic [WIDTH-1:0] din;

`ifdef IREG_SKEW_ZERO_FILL_EN
        // A bubble enters as zero; later stages then stay zero for it automatically.
        assign din = stage0_vld ? bus.i_data[c*WIDTH +: WIDTH] : '0;
`else
        assign din = bus.i_data[c*WIDTH +: WIDTH];
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int k = 0; k < DEP; k++) dat_q[k] <= '0;
            end else if (bus.clr) begin
                vld_q <= '0;
                for (int k = 0; k < DEP; k++) dat_q[k] <= '0;
            end else if (bus.en) begin
                vld_q[0] <= stage0_vld;
                dat_q[0] <= din;
                for (int k = 1; k < DEP; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end

        assign o_valid_w[c]                = vld_q[DEP-1];
        assign o_data_w[c*WIDTH +: WIDTH]  = dat_q[DEP-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE, RUN: begin
                    if (accept) begin
                        if (bus.i_last) begin
                            // With a single-register skew the last word is already out.
                            if (LOAD == '0) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = DRAIN;
                                cnt_d   = LOAD;
                            end
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // done_d is 0 on stalled edges, so o_done never stretches past one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (bus.clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.i_ready = ready;
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_done  = done_q;
    assign bus.o_valid = o_valid_w;
    assign bus.o_data  = o_data_w;
endmodule

// File: tb/tb_ireg_skew_array.sv
// Bench for ireg_skew_array: directed cases with literal expectations plus a randomized run
// compared every cycle against a history-queue model; a second CHANNELS=1 instance covers D=1.
module tb_ireg_skew_array;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int BD = 1;
    localparam int D  = BD + CH - 1;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    ireg_skew_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
    ireg_skew_if #(.WIDTH(W), .CHANNELS(1))  dbus ();

    ireg_skew_array #(.WIDTH(W), .CHANNELS(CH), .BASE_DEPTH(BD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ireg_skew_array #(.WIDTH(W), .CHANNELS(1), .BASE_DEPTH(1)) u_deg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: the vector seen at each enabled edge, newest first; channel c shows entry BD+c-1.
    typedef struct {
        logic              v;
        logic [CH*W-1:0]   d;
    } ent_t;

    ent_t mq[$];
    int   n_edge    = 0;
    int   drain_end = -1;
    bit   in_frame  = 1'b0;
    bit   done_exp  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        ent_t e;
        bit   acc;
        if (!rst_n || bus.clr) begin
            mq.delete();
            n_edge    = 0;
            drain_end = -1;
            in_frame  = 1'b0;
            done_exp  = 1'b0;
        end else begin
            done_exp = 1'b0;
            if (bus.en) begin
                acc = bus.i_valid && (drain_end < 0);
                e.v = acc;
                e.d = bus.i_data;
`ifdef IREG_SKEW_ZERO_FILL_EN
                if (!acc) e.d = '0;
`endif
                mq.push_front(e);
                if (mq.size() > D) void'(mq.pop_back());
                if (drain_end == n_edge) begin
                    done_exp  = 1'b1;
                    drain_end = -1;
                end else if (acc) begin
                    if (bus.i_last) begin
                        in_frame = 1'b0;
                        if (D == 1) done_exp = 1'b1;
                        else drain_end = n_edge + D - 1;
                    end else begin
                        in_frame = 1'b1;
                    end
                end
                n_edge++;
            end
        end
    end

    always @(negedge clk) begin
        logic [CH-1:0]   ev;
        logic [CH*W-1:0] ed;
        ev = '0;
        ed = '0;
        for (int c = 0; c < CH; c++) begin
            if (BD + c - 1 < mq.size()) begin
                ev[c]         = mq[BD+c-1].v;
                ed[c*W +: W]  = mq[BD+c-1].d[c*W +: W];
            end
        end
        chk("m_o_valid", 64'(bus.o_valid), 64'(ev));
        chk("m_o_data",  64'(bus.o_data),  64'(ed));
        chk("m_o_done",  64'(bus.o_done),  64'(done_exp));
        chk("m_o_busy",  64'(bus.o_busy),  64'(in_frame || drain_end >= 0));
        chk("m_i_ready", 64'(bus.i_ready), 64'(drain_end < 0));
    end

    task automatic cyc(input bit en, input bit clr, input bit v, input bit last,
                       input logic [CH*W-1:0] data);
        bus.en      = en;
        bus.clr     = clr;
        bus.i_valid = v;
        bus.i_last  = last;
        bus.i_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic clear1();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [CH*W-1:0] vc;
        logic [CH*W-1:0] vs;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.clr      = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_last   = 1'b0;
        bus.i_data   = '0;
        dbus.en      = 1'b1;
        dbus.clr     = 1'b0;
        dbus.i_valid = 1'b0;
        dbus.i_last  = 1'b0;
        dbus.i_data  = '0;
        #12 rst_n = 1'b1;
        #1;
        chk("rst_o_valid", 64'(bus.o_valid), 64'h0);
        chk("rst_o_data",  64'(bus.o_data),  64'h0);
        chk("rst_i_ready", 64'(bus.i_ready), 64'h1);
        chk("rst_o_busy",  64'(bus.o_busy),  64'h0);
        chk("rst_o_done",  64'(bus.o_done),  64'h0);

        // Skew: one vector walks the diagonal
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {16'd4, 16'd3, 16'd2, 16'd1});
        chk("skew_v_e0", 64'(bus.o_valid), 64'b0001);
        chk("skew_d_e0", 64'(bus.o_data[15:0]), 64'd1);
        idle1();
        chk("skew_v_e1", 64'(bus.o_valid), 64'b0010);
        chk("skew_d_e1", 64'(bus.o_data[31:16]), 64'd2);
        idle1();
        chk("skew_v_e2", 64'(bus.o_valid), 64'b0100);
        chk("skew_d_e2", 64'(bus.o_data[47:32]), 64'd3);
        idle1();
        chk("skew_v_e3", 64'(bus.o_valid), 64'b1000);
        chk("skew_d_e3", 64'(bus.o_data[63:48]), 64'd4);
        chk("skew_busy", 64'(bus.o_busy), 64'h1);

        // Frame drain: third vector carries last, drain input is dropped
        clear1();
        vc = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {4{16'h00A0}});
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {4{16'h00B0}});
        cyc(1'b1, 1'b0, 1'b1, 1'b1, vc);
        chk("frm_ready_e2", 64'(bus.i_ready), 64'h0);
        chk("frm_busy_e2",  64'(bus.o_busy),  64'h1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {4{16'hFFFF}});
        chk("frm_drop_v0", 64'(bus.o_valid[0]), 64'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {4{16'hFFFF}});
        chk("frm_done_e4", 64'(bus.o_done), 64'h0);
        idle1();
        chk("frm_done_e5", 64'(bus.o_done), 64'h1);
        chk("frm_v3_e5",   64'(bus.o_valid[3]), 64'h1);
        chk("frm_d3_e5",   64'(bus.o_data[63:48]), 64'h00C3);
        chk("frm_ready_e5", 64'(bus.i_ready), 64'h1);
        chk("frm_busy_e5",  64'(bus.o_busy),  64'h0);
        idle1();
        chk("frm_done_e6", 64'(bus.o_done), 64'h0);

        // Stall during drain: five en=0 cycles push o_done out by five
        clear1();
        vs = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        cyc(1'b1, 1'b0, 1'b1, 1'b1, vs);
        idle1();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, {4{16'h5555}});
            chk("stl_v",    64'(bus.o_valid), 64'b0010);
            chk("stl_d1",   64'(bus.o_data[31:16]), 64'h0011);
            chk("stl_done", 64'(bus.o_done), 64'h0);
        end
        idle1();
        chk("stl_done_e2", 64'(bus.o_done), 64'h0);
        idle1();
        chk("stl_done_e3", 64'(bus.o_done), 64'h1);
        chk("stl_d3_e3",   64'(bus.o_data[63:48]), 64'h0013);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("stl_done_1clk", 64'(bus.o_done), 64'h0);

        // Clear mid-RUN while en is low
        clear1();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {4{16'h0077}});
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("clr_v",    64'(bus.o_valid), 64'h0);
        chk("clr_d",    64'(bus.o_data),  64'h0);
        chk("clr_busy", 64'(bus.o_busy),  64'h0);
        chk("clr_done", 64'(bus.o_done),  64'h0);

        // Async reset during drain aborts the frame
        cyc(1'b1, 1'b0, 1'b1, 1'b1, {4{16'h0099}});
        idle1();
        #1 rst_n = 1'b0;
        #1;
        chk("ars_v",     64'(bus.o_valid), 64'h0);
        chk("ars_d",     64'(bus.o_data),  64'h0);
        chk("ars_busy",  64'(bus.o_busy),  64'h0);
        chk("ars_ready", 64'(bus.i_ready), 64'h1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle1();
            chk("ars_no_done", 64'(bus.o_done), 64'h0);
        end

        // Bubbles carrying 7FFF, then extreme signed values
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, {4{16'h7FFF}});
        chk("bub_v", 64'(bus.o_valid), 64'h0);
`ifdef IREG_SKEW_ZERO_FILL_EN
        chk("bub_d", 64'(bus.o_data), 64'h0);
`else
        chk("bub_d", 64'(bus.o_data), {4{16'h7FFF}});
`endif
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000});
        chk("sgn_d0", 64'(bus.o_data[15:0]), 64'h8000);
        idle1();
        chk("sgn_d1", 64'(bus.o_data[31:16]), 64'h7FFF);
        idle1();
        idle1();
        chk("sgn_d3", 64'(bus.o_data[63:48]), 64'h7FFF);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 8,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 2,
                {$urandom, $urandom});
        end
        clear1();

        // Degenerate CHANNELS=1, BASE_DEPTH=1: done with the data, back-to-back accept
        dbus.i_valid = 1'b1;
        dbus.i_last  = 1'b1;
        dbus.i_data  = 16'h1234;
        @(posedge clk);
        #1;
        chk("deg_done",  64'(dbus.o_done),  64'h1);
        chk("deg_v",     64'(dbus.o_valid), 64'h1);
        chk("deg_d",     64'(dbus.o_data),  64'h1234);
        chk("deg_busy",  64'(dbus.o_busy),  64'h0);
        chk("deg_ready", 64'(dbus.i_ready), 64'h1);
        dbus.i_last = 1'b0;
        dbus.i_data = 16'h5678;
        @(posedge clk);
        #1;
        chk("deg_done2", 64'(dbus.o_done),  64'h0);
        chk("deg_v2",    64'(dbus.o_valid), 64'h1);
        chk("deg_d2",    64'(dbus.o_data),  64'h5678);
        chk("deg_busy2", 64'(dbus.o_busy),  64'h1);
        dbus.i_valid = 1'b0;

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
